// File: rtl/sdram_rd_arbiter_if.sv
// Read-port handshake bundle shared by the requesters and the SDRAM controller:
// rd/addr_x16 request, rdy/rdata level data valid, ack one-cycle consume.
interface sdram_rd_arbiter_if;
  localparam int unsigned ADDR_W = 24;
  localparam int unsigned DATA_W = 16;

  logic              rd;
  logic [ADDR_W-1:0] addr_x16;
  logic              ack;
  logic              rdy;
  logic [DATA_W-1:0] rdata;

  // master issues requests and consumes data; slave serves them
  modport master (output rd, output addr_x16, output ack, input rdy, input rdata);
  modport slave  (input rd, input addr_x16, input ack, output rdy, output rdata);
endinterface

// File: rtl/sdram_rd_arbiter.sv
// Two-master SDRAM read-port arbiter: master 0 (scanout) has priority over master 1.
// Define SDRAM_ARB_FAIRNESS_EN to bound master-1 starvation to MAX_M0_RUN m0 grants.
module sdram_rd_arbiter #(
  parameter int unsigned MAX_M0_RUN = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  sdram_rd_arbiter_if.slave        m0,
  sdram_rd_arbiter_if.slave        m1,
  sdram_rd_arbiter_if.master       sdram,
  output logic [1:0]               grant_o
);

  localparam int unsigned ADDR_W = 24;
  localparam int unsigned RUN_W  = 4;

  if (MAX_M0_RUN < 1 || MAX_M0_RUN > 15) begin : g_bad_max_run
    $error("MAX_M0_RUN must lie within 1..15");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT0    = 2'd1,
    GNT1    = 2'd2,
    RELEASE = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic              sdram_rd_q, sdram_rd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        grant_q, grant_d;
  logic              pick0_c, pick1_c;
  logic              ack_c;

`ifdef SDRAM_ARB_FAIRNESS_EN
  localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(MAX_M0_RUN);

  logic [RUN_W-1:0] run0_q, run0_d;
  logic             force1_c;

  assign force1_c = m1.rd && (run0_q == RUN_LIMIT);
`endif

  // Arbitration decision, only meaningful in IDLE
  always_comb begin
    pick0_c = 1'b0;
    pick1_c = 1'b0;
    if (state_q == IDLE) begin
`ifdef SDRAM_ARB_FAIRNESS_EN
      if (force1_c)      pick1_c = 1'b1;
      else if (m0.rd)    pick0_c = 1'b1;
      else if (m1.rd)    pick1_c = 1'b1;
`else
      if (m0.rd)         pick0_c = 1'b1;
      else if (m1.rd)    pick1_c = 1'b1;
`endif
    end
  end

`ifdef SDRAM_ARB_FAIRNESS_EN
  // Counts m0 grants that overtook a waiting m1; never passes RUN_LIMIT
  always_comb begin
    run0_d = run0_q;
    if (state_q == IDLE) begin
      if (pick1_c || !m1.rd) run0_d = '0;
      else if (pick0_c)      run0_d = run0_q + RUN_W'(1);
    end
  end
`endif

  // Zero-latency data path; an aborted read is drained by acking it here
  always_comb begin
    m0.rdy   = 1'b0;
    m0.rdata = '0;
    m1.rdy   = 1'b0;
    m1.rdata = '0;
    ack_c    = 1'b0;
    case (state_q)
      GNT0: begin
        m0.rdy   = sdram.rdy & m0.rd;
        m0.rdata = sdram.rdata;
        ack_c    = sdram.rdy & (m0.ack | ~m0.rd);
      end
      GNT1: begin
        m1.rdy   = sdram.rdy & m1.rd;
        m1.rdata = sdram.rdata;
        ack_c    = sdram.rdy & (m1.ack | ~m1.rd);
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    sdram_rd_d = sdram_rd_q;
    addr_d     = addr_q;
    grant_d    = grant_q;
    case (state_q)
      IDLE: begin
        if (pick0_c) begin
          state_d    = GNT0;
          sdram_rd_d = 1'b1;
          addr_d     = m0.addr_x16;
          grant_d    = 2'b01;
        end else if (pick1_c) begin
          state_d    = GNT1;
          sdram_rd_d = 1'b1;
          addr_d     = m1.addr_x16;
          grant_d    = 2'b10;
        end
      end
      GNT0, GNT1: begin
        if (ack_c) begin
          state_d    = RELEASE;
          sdram_rd_d = 1'b0;
          grant_d    = 2'b00;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      sdram_rd_q <= 1'b0;
      addr_q     <= '0;
      grant_q    <= 2'b00;
`ifdef SDRAM_ARB_FAIRNESS_EN
      run0_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      sdram_rd_q <= sdram_rd_d;
      addr_q     <= addr_d;
      grant_q    <= grant_d;
`ifdef SDRAM_ARB_FAIRNESS_EN
      run0_q     <= run0_d;
`endif
    end
  end

  assign sdram.rd       = sdram_rd_q;
  assign sdram.addr_x16 = addr_q;
  assign sdram.ack      = ack_c;
  assign grant_o        = grant_q;

endmodule

// File: tb/tb_sdram_rd_arbiter.sv
// Directed self-checking bench for sdram_rd_arbiter; the SDRAM controller is played
// by the bench driving rdy/rdata. Fairness expectations follow SDRAM_ARB_FAIRNESS_EN.
module tb_sdram_rd_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] grant;
  int         checks = 0;
  int         errors = 0;

  sdram_rd_arbiter_if m0_if ();
  sdram_rd_arbiter_if m1_if ();
  sdram_rd_arbiter_if sd_if ();

  sdram_rd_arbiter #(.MAX_M0_RUN(4)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .m0      (m0_if),
    .m1      (m1_if),
    .sdram   (sd_if),
    .grant_o (grant)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m0_if.rd = 1'b0; m0_if.addr_x16 = '0; m0_if.ack = 1'b0;
    m1_if.rd = 1'b0; m1_if.addr_x16 = '0; m1_if.ack = 1'b0;
    sd_if.rdy = 1'b0; sd_if.rdata = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    #3;
    checks++; if (sd_if.rd !== 1'b0) begin errors++; $display("FAIL rst_sdram_rd got %b want 0", sd_if.rd); end
    checks++; if (sd_if.addr_x16 !== 24'h0) begin errors++; $display("FAIL rst_addr got %h want 000000", sd_if.addr_x16); end
    checks++; if (sd_if.ack !== 1'b0) begin errors++; $display("FAIL rst_sdram_ack got %b want 0", sd_if.ack); end
    checks++; if (m0_if.rdy !== 1'b0 || m1_if.rdy !== 1'b0) begin errors++; $display("FAIL rst_rdy got %b%b want 00", m1_if.rdy, m0_if.rdy); end
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL rst_grant got %b want 00", grant); end
    @(negedge clk);
    rst = 1'b0;
    tick();
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL idle_grant got %b want 00", grant); end
  endtask

  task automatic test_single_m1();
    m1_if.rd = 1'b1; m1_if.addr_x16 = 24'h123456;
    tick();
    checks++; if (sd_if.rd !== 1'b1) begin errors++; $display("FAIL m1_sdram_rd got %b want 1", sd_if.rd); end
    checks++; if (sd_if.addr_x16 !== 24'h123456) begin errors++; $display("FAIL m1_addr got %h want 123456", sd_if.addr_x16); end
    checks++; if (grant !== 2'b10) begin errors++; $display("FAIL m1_grant got %b want 10", grant); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (m1_if.rdy !== 1'b0 || sd_if.rd !== 1'b1) begin errors++; $display("FAIL m1_wait%0d rdy %b rd %b want 0 1", i, m1_if.rdy, sd_if.rd); end
    end
    sd_if.rdy = 1'b1; sd_if.rdata = 16'hBEEF;
    #1;
    checks++; if (m1_if.rdy !== 1'b1) begin errors++; $display("FAIL m1_rdy got %b want 1", m1_if.rdy); end
    checks++; if (m1_if.rdata !== 16'hBEEF) begin errors++; $display("FAIL m1_rdata got %h want beef", m1_if.rdata); end
    checks++; if (sd_if.ack !== 1'b0) begin errors++; $display("FAIL m1_noack got %b want 0", sd_if.ack); end
    checks++; if (m0_if.rdy !== 1'b0 || m0_if.rdata !== 16'h0) begin errors++; $display("FAIL m0_isolated rdy %b rdata %h want 0 0000", m0_if.rdy, m0_if.rdata); end
    tick();
    m1_if.ack = 1'b1;
    #1;
    checks++; if (sd_if.ack !== 1'b1) begin errors++; $display("FAIL m1_ack_fwd got %b want 1", sd_if.ack); end
    tick();
    m1_if.rd = 1'b0; m1_if.ack = 1'b0; sd_if.rdy = 1'b0;
    checks++; if (sd_if.rd !== 1'b0 || grant !== 2'b00) begin errors++; $display("FAIL m1_release rd %b grant %b want 0 00", sd_if.rd, grant); end
    tick();
    checks++; if (sd_if.rd !== 1'b0) begin errors++; $display("FAIL m1_idle_rd got %b want 0", sd_if.rd); end
  endtask

  task automatic test_collision_stray_ack();
    m0_if.rd = 1'b1; m0_if.addr_x16 = 24'hA00000;
    m1_if.rd = 1'b1; m1_if.addr_x16 = 24'h0000B1;
    tick();
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL col_grant got %b want 01", grant); end
    checks++; if (sd_if.addr_x16 !== 24'hA00000) begin errors++; $display("FAIL col_addr got %h want a00000", sd_if.addr_x16); end
    sd_if.rdy = 1'b1; sd_if.rdata = 16'h1111;
    #1;
    checks++; if (m0_if.rdy !== 1'b1 || m0_if.rdata !== 16'h1111) begin errors++; $display("FAIL col_m0_data rdy %b rdata %h want 1 1111", m0_if.rdy, m0_if.rdata); end
    checks++; if (m1_if.rdy !== 1'b0 || m1_if.rdata !== 16'h0) begin errors++; $display("FAIL col_m1_blocked rdy %b rdata %h want 0 0000", m1_if.rdy, m1_if.rdata); end
    m1_if.ack = 1'b1;
    #1;
    checks++; if (sd_if.ack !== 1'b0) begin errors++; $display("FAIL stray_ack got %b want 0", sd_if.ack); end
    tick();
    checks++; if (grant !== 2'b01 || sd_if.rd !== 1'b1) begin errors++; $display("FAIL stray_hold grant %b rd %b want 01 1", grant, sd_if.rd); end
    m1_if.ack = 1'b0; m0_if.ack = 1'b1;
    #1;
    checks++; if (sd_if.ack !== 1'b1) begin errors++; $display("FAIL col_m0_ack got %b want 1", sd_if.ack); end
    tick();
    m0_if.rd = 1'b0; m0_if.ack = 1'b0; sd_if.rdy = 1'b0;
    checks++; if (grant !== 2'b00 || sd_if.rd !== 1'b0) begin errors++; $display("FAIL col_release grant %b rd %b want 00 0", grant, sd_if.rd); end
    tick();
    checks++; if (sd_if.rd !== 1'b0) begin errors++; $display("FAIL col_turnaround got %b want 0", sd_if.rd); end
    tick();
    checks++; if (grant !== 2'b10 || sd_if.addr_x16 !== 24'h0000B1) begin errors++; $display("FAIL col_m1_next grant %b addr %h want 10 0000b1", grant, sd_if.addr_x16); end
    sd_if.rdy = 1'b1; sd_if.rdata = 16'h2222; m1_if.ack = 1'b1;
    #1;
    checks++; if (m1_if.rdata !== 16'h2222 || sd_if.ack !== 1'b1) begin errors++; $display("FAIL col_m1_data rdata %h ack %b want 2222 1", m1_if.rdata, sd_if.ack); end
    tick();
    m1_if.rd = 1'b0; m1_if.ack = 1'b0; sd_if.rdy = 1'b0;
    tick();
  endtask

  task automatic test_abort();
    m0_if.rd = 1'b1; m0_if.addr_x16 = 24'h00C0DE;
    tick();
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL abort_grant got %b want 01", grant); end
    tick();
    tick();
    m0_if.rd = 1'b0;
    #1;
    checks++; if (sd_if.rd !== 1'b1) begin errors++; $display("FAIL abort_hold_rd got %b want 1", sd_if.rd); end
    tick();
    checks++; if (sd_if.rd !== 1'b1 || sd_if.ack !== 1'b0) begin errors++; $display("FAIL abort_wait rd %b ack %b want 1 0", sd_if.rd, sd_if.ack); end
    sd_if.rdy = 1'b1; sd_if.rdata = 16'hDEAD;
    #1;
    checks++; if (sd_if.ack !== 1'b1) begin errors++; $display("FAIL abort_self_ack got %b want 1", sd_if.ack); end
    checks++; if (m0_if.rdy !== 1'b0) begin errors++; $display("FAIL abort_m0_rdy got %b want 0", m0_if.rdy); end
    tick();
    sd_if.rdy = 1'b0;
    checks++; if (sd_if.rd !== 1'b0 || grant !== 2'b00) begin errors++; $display("FAIL abort_release rd %b grant %b want 0 00", sd_if.rd, grant); end
    tick();
    checks++; if (sd_if.ack !== 1'b0 || sd_if.rd !== 1'b0) begin errors++; $display("FAIL abort_idle ack %b rd %b want 0 0", sd_if.ack, sd_if.rd); end
  endtask

  task automatic test_fairness();
    logic [1:0] exp_gnt [6];
`ifdef SDRAM_ARB_FAIRNESS_EN
    exp_gnt = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01};
`else
    exp_gnt = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01};
`endif
    m0_if.rd = 1'b1; m0_if.addr_x16 = 24'h000100;
    m1_if.rd = 1'b1; m1_if.addr_x16 = 24'h000200;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++; if (grant !== exp_gnt[i]) begin errors++; $display("FAIL fair_grant%0d got %b want %b", i, grant, exp_gnt[i]); end
      sd_if.rdy = 1'b1; sd_if.rdata = 16'(i);
      m0_if.ack = grant[0]; m1_if.ack = grant[1];
      tick();
      m0_if.ack = 1'b0; m1_if.ack = 1'b0; sd_if.rdy = 1'b0;
      tick();
    end
    m0_if.rd = 1'b0; m1_if.rd = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    m0_if.rd = 1'b1; m0_if.addr_x16 = 24'h777777;
    tick();
    sd_if.rdy = 1'b1; sd_if.rdata = 16'hCAFE;
    #1;
    checks++; if (m0_if.rdy !== 1'b1 || sd_if.ack !== 1'b0) begin errors++; $display("FAIL mid_pre rdy %b ack %b want 1 0", m0_if.rdy, sd_if.ack); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (sd_if.rd !== 1'b0 || sd_if.ack !== 1'b0) begin errors++; $display("FAIL mid_rst_sdram rd %b ack %b want 0 0", sd_if.rd, sd_if.ack); end
    checks++; if (sd_if.addr_x16 !== 24'h0) begin errors++; $display("FAIL mid_rst_addr got %h want 000000", sd_if.addr_x16); end
    checks++; if (m0_if.rdy !== 1'b0 || m0_if.rdata !== 16'h0) begin errors++; $display("FAIL mid_rst_m0 rdy %b rdata %h want 0 0000", m0_if.rdy, m0_if.rdata); end
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL mid_rst_grant got %b want 00", grant); end
    #1;
    rst = 1'b0;
    sd_if.rdy = 1'b0;
    m0_if.addr_x16 = 24'h0ABCDE;
    tick();
    checks++; if (grant !== 2'b01 || sd_if.rd !== 1'b1 || sd_if.addr_x16 !== 24'h0ABCDE) begin errors++; $display("FAIL post_rst_grant grant %b rd %b addr %h want 01 1 0abcde", grant, sd_if.rd, sd_if.addr_x16); end
    sd_if.rdy = 1'b1; sd_if.rdata = 16'h5A5A; m0_if.ack = 1'b1;
    #1;
    checks++; if (m0_if.rdata !== 16'h5A5A || sd_if.ack !== 1'b1) begin errors++; $display("FAIL post_rst_data rdata %h ack %b want 5a5a 1", m0_if.rdata, sd_if.ack); end
    tick();
    m0_if.rd = 1'b0; m0_if.ack = 1'b0; sd_if.rdy = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_m1();
    test_collision_stray_ack();
    test_abort();
    test_fairness();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
